// File: rtl/updown_count_checker_if.sv
// ---------------------------------------------------------------------------
// updown_count_checker_if
//   Bundles the signals between an UpDownCount counter pair (plus its
//   enable/swap controls) and the updown_count_checker monitor.
//
//   enable        counter enable, same level that drives the counter
//   swap          counter swap request, level; the rising edge is the event
//   up_count_s    counter output A
//   down_count_s  counter output B
//   locked        1 while the checker is tracking
//   up_dir        learned direction of up_count_s   (1 = +1/step, 0 = -1/step)
//   down_dir      learned direction of down_count_s (same encoding)
//   error_pulse   one-cycle pulse per detected mismatch
//   error_count   saturating total of mismatches
//
//   master: the side that drives the counter signals and reads the status.
//   slave : the checker itself.
// ---------------------------------------------------------------------------
interface updown_count_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 enable;
  logic                 swap;
  logic [WIDTH-1:0]     up_count_s;
  logic [WIDTH-1:0]     down_count_s;
  logic                 locked;
  logic                 up_dir;
  logic                 down_dir;
  logic                 error_pulse;
  logic [ERR_CNT_W-1:0] error_count;

  modport master (
    output enable, swap, up_count_s, down_count_s,
    input  locked, up_dir, down_dir, error_pulse, error_count
  );

  modport slave (
    input  enable, swap, up_count_s, down_count_s,
    output locked, up_dir, down_dir, error_pulse, error_count
  );
endinterface

// File: rtl/updown_count_checker.sv
// ---------------------------------------------------------------------------
// updown_count_checker
//   Consumer-side monitor for the UpDownCount counter pair. Registers the
//   counter signals every rising clk edge, learns the count direction of each
//   channel, then checks each subsequent step against the learned direction.
//
//   Ports
//     clk   in  clock, rising edge
//     rst   in  asynchronous, active-high reset
//     bus   slave modport of updown_count_checker_if (see that file)
//
//   Parameters
//     WIDTH        width of the counter outputs; steps are modulo 2**WIDTH
//     ERR_CNT_W    width of the saturating error counter
//     LOCK_CYCLES  consecutive consistent enabled steps needed to lock (>=1)
//
//   Timing: inputs are captured into s_* at edge N and judged against the
//   previous capture at edge N+1, so a bad sample at edge N shows up on
//   error_pulse after edge N+1, and locked rises one cycle after the
//   locking step.
// ---------------------------------------------------------------------------
module updown_count_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_CNT_W   = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  updown_count_checker_if.slave  bus
);

  localparam int ACQ_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    TRACK
  } state_t;

  state_t               state;

  // Input capture stage and one-cycle history.
  logic [WIDTH-1:0]     s_up, s_down;
  logic                 s_en, s_swap;
  logic [WIDTH-1:0]     prev_up, prev_down;
  logic                 en_d, swap_d;

  // Acquisition bookkeeping: run length and directions of the last good step.
  logic [ACQ_W-1:0]     acq_cnt;
  logic                 last_up_dir, last_down_dir;

  // Registered outputs.
  logic                 locked, up_dir, down_dir, error_pulse;
  logic [ERR_CNT_W-1:0] error_count;

  // Step classification of the captured sample against the previous one.
  logic                 swap_ev;
  logic                 up_inc, up_dec, down_inc, down_dec;
  logic                 both_step, both_hold, same_dirs;
  logic [ACQ_W-1:0]     acq_next;
  logic                 lock_hit;
  logic [WIDTH-1:0]     exp_up, exp_down;
  logic                 mismatch;

  assign swap_ev   = s_swap & ~swap_d;
  assign up_inc    = (s_up   == prev_up   + WIDTH'(1));
  assign up_dec    = (s_up   == prev_up   - WIDTH'(1));
  assign down_inc  = (s_down == prev_down + WIDTH'(1));
  assign down_dec  = (s_down == prev_down - WIDTH'(1));
  assign both_step = (up_inc | up_dec) & (down_inc | down_dec);
  assign both_hold = (s_up == prev_up) & (s_down == prev_down);
  // A zero run has no "previous step" to agree with, so it restarts at 1.
  assign same_dirs = (acq_cnt != '0) & (up_inc == last_up_dir) &
                     (down_inc == last_down_dir);

  always_comb begin
    // NOTE: default first so every path assigns acq_next; no latch inferred.
    acq_next = acq_cnt;
    if (en_d) begin
      if (both_step) acq_next = same_dirs ? acq_cnt + 1'b1 : ACQ_W'(1);
      else           acq_next = '0;
    end else if (!both_hold) begin
      acq_next = '0;
    end
  end

  // Reaching LOCK_CYCLES always implies the current step was a legal move,
  // so up_inc/down_inc are the directions to latch.
  assign lock_hit = (acq_next == ACQ_W'(LOCK_CYCLES));

  assign exp_up   = !en_d  ? prev_up   :
                    up_dir ? prev_up   + WIDTH'(1) : prev_up   - WIDTH'(1);
  assign exp_down = !en_d    ? prev_down :
                    down_dir ? prev_down + WIDTH'(1) : prev_down - WIDTH'(1);
  // Both channels wrong together still count as a single error.
  assign mismatch = (s_up != exp_up) | (s_down != exp_down);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      s_up          <= '0;
      s_down        <= '0;
      s_en          <= 1'b0;
      s_swap        <= 1'b0;
      prev_up       <= '0;
      prev_down     <= '0;
      en_d          <= 1'b0;
      swap_d        <= 1'b0;
      acq_cnt       <= '0;
      last_up_dir   <= 1'b0;
      last_down_dir <= 1'b0;
      locked        <= 1'b0;
      up_dir        <= 1'b1;
      down_dir      <= 1'b0;
      error_pulse   <= 1'b0;
      error_count   <= '0;
    end else begin
      // History shifts every cycle; in TRACK this is also the resync that
      // keeps a single glitch down to a single error.
      s_up      <= bus.up_count_s;
      s_down    <= bus.down_count_s;
      s_en      <= bus.enable;
      s_swap    <= bus.swap;
      prev_up   <= s_up;
      prev_down <= s_down;
      en_d      <= s_en;
      swap_d    <= s_swap;

      if (swap_ev) begin
        // Swap wins over anything else this cycle; its step is ignored.
        state       <= ACQUIRE;
        acq_cnt     <= '0;
        locked      <= 1'b0;
        error_pulse <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            // First ACQUIRE evaluation compares against cleared history; the
            // worst it can do is leave acq_cnt at zero.
            state       <= ACQUIRE;
            acq_cnt     <= '0;
            error_pulse <= 1'b0;
          end
          ACQUIRE: begin
            error_pulse <= 1'b0;
            acq_cnt     <= acq_next;
            if (en_d && both_step) begin
              last_up_dir   <= up_inc;
              last_down_dir <= down_inc;
            end
            if (lock_hit) begin
              state    <= TRACK;
              locked   <= 1'b1;
              up_dir   <= up_inc;
              down_dir <= down_inc;
            end
          end
          TRACK: begin
            error_pulse <= mismatch;
            if (mismatch && (error_count != '1))
              error_count <= error_count + 1'b1;
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked      = locked;
  assign bus.up_dir      = up_dir;
  assign bus.down_dir    = down_dir;
  assign bus.error_pulse = error_pulse;
  assign bus.error_count = error_count;

endmodule

// File: tb/tb_updown_count_checker.sv
// ---------------------------------------------------------------------------
// tb_updown_count_checker
//   Self-checking bench for updown_count_checker. Each clock step drives the
//   counter signals, advances a behavioural reference model, queues the
//   model's expected outputs and compares them with the DUT 1 time unit
//   after the edge. Each scenario task also checks the headline values it is
//   about against fixed constants.
// ---------------------------------------------------------------------------
module tb_updown_count_checker;

  localparam int WIDTH       = 4;
  localparam int ERR_CNT_W   = 8;
  localparam int LOCK_CYCLES = 2;
  localparam int MOD         = 1 << WIDTH;

  typedef struct packed {
    logic                 locked;
    logic                 up_dir;
    logic                 down_dir;
    logic                 error_pulse;
    logic [ERR_CNT_W-1:0] error_count;
  } obs_t;

  localparam obs_t RST_OBS = '{locked: 1'b0, up_dir: 1'b1, down_dir: 1'b0,
                               error_pulse: 1'b0, error_count: '0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  updown_count_checker_if #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W)) bus ();

  updown_count_checker #(
    .WIDTH(WIDTH), .ERR_CNT_W(ERR_CNT_W), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  obs_t exp_q[$];

  // ---------------- reference model ----------------
  int               m_st;     // 0 idle, 1 acquire, 2 track
  int               m_cnt;
  logic             m_lu, m_ld;
  logic [WIDTH-1:0] ms_up, ms_dn, mp_up, mp_dn;
  logic             ms_en, ms_sw, m_en_d, m_sw_d;
  obs_t             m_out;

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_lu = 1'b0; m_ld = 1'b0;
    ms_up = '0; ms_dn = '0; mp_up = '0; mp_dn = '0;
    ms_en = 1'b0; ms_sw = 1'b0; m_en_d = 1'b0; m_sw_d = 1'b0;
    m_out = RST_OBS;
  endtask

  task automatic model_edge(input logic en, input logic sw,
                            input logic [WIDTH-1:0] up, input logic [WIDTH-1:0] dn);
    int du, dd, eu, ed;
    du = (int'(ms_up) - int'(mp_up) + MOD) % MOD;
    dd = (int'(ms_dn) - int'(mp_dn) + MOD) % MOD;
    if (ms_sw && !m_sw_d) begin
      m_st = 1; m_cnt = 0; m_out.locked = 1'b0; m_out.error_pulse = 1'b0;
    end else if (m_st == 0) begin
      m_st = 1; m_out.error_pulse = 1'b0;
    end else if (m_st == 1) begin
      m_out.error_pulse = 1'b0;
      if (m_en_d) begin
        if ((du == 1 || du == MOD-1) && (dd == 1 || dd == MOD-1)) begin
          if (m_cnt > 0 && m_lu == (du == 1) && m_ld == (dd == 1)) m_cnt++;
          else m_cnt = 1;
          m_lu = (du == 1); m_ld = (dd == 1);
        end else m_cnt = 0;
      end else if (du != 0 || dd != 0) m_cnt = 0;
      if (m_cnt == LOCK_CYCLES) begin
        m_st = 2; m_out.locked = 1'b1; m_out.up_dir = m_lu; m_out.down_dir = m_ld;
      end
    end else begin
      eu = !m_en_d ? 0 : (m_out.up_dir   ? 1 : MOD-1);
      ed = !m_en_d ? 0 : (m_out.down_dir ? 1 : MOD-1);
      m_out.error_pulse = ((int'(mp_up) + eu) % MOD != int'(ms_up)) ||
                          ((int'(mp_dn) + ed) % MOD != int'(ms_dn));
      if (m_out.error_pulse && m_out.error_count != '1)
        m_out.error_count = m_out.error_count + 1'b1;
    end
    mp_up = ms_up; mp_dn = ms_dn; m_en_d = ms_en; m_sw_d = ms_sw;
    ms_up = up; ms_dn = dn; ms_en = en; ms_sw = sw;
  endtask

  function automatic obs_t observe();
    return '{locked: bus.locked, up_dir: bus.up_dir, down_dir: bus.down_dir,
             error_pulse: bus.error_pulse, error_count: bus.error_count};
  endfunction

  // One clock step: drive, model, queue, compare.
  task automatic step(input logic en, input logic sw,
                      input logic [WIDTH-1:0] up, input logic [WIDTH-1:0] dn);
    obs_t e, a;
    bus.enable = en; bus.swap = sw; bus.up_count_s = up; bus.down_count_s = dn;
    @(posedge clk);
    model_edge(en, sw, up, dn);
    exp_q.push_back(m_out);
    #1;
    a = observe();
    e = exp_q.pop_front();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL step t=%0t in(en=%b sw=%b up=%h dn=%h) got lk=%b ud=%b dd=%b ep=%b ec=%0d want lk=%b ud=%b dd=%b ep=%b ec=%0d",
               $time, en, sw, up, dn, a.locked, a.up_dir, a.down_dir, a.error_pulse,
               a.error_count, e.locked, e.up_dir, e.down_dir, e.error_pulse, e.error_count);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    obs_t a;
    rst = 1'b1;
    bus.enable = 1'b0; bus.swap = 1'b0; bus.up_count_s = '0; bus.down_count_s = '0;
    model_reset();
    #1;
    a = observe();
    n_cmp++;
    if (a !== RST_OBS) begin
      n_bad++; $display("FAIL reset_async got %h want %h", a, RST_OBS);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a = observe();
      n_cmp++;
      if (a !== RST_OBS) begin
        n_bad++; $display("FAIL reset_hold cycle %0d got %h want %h", i, a, RST_OBS);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_lock();
    step(1'b1, 1'b0, 4'h0, 4'hF);
    step(1'b1, 1'b0, 4'h1, 4'hE);
    step(1'b1, 1'b0, 4'h2, 4'hD);
    n_cmp++;
    if (bus.locked !== 1'b0) begin
      n_bad++; $display("FAIL lock_early locked=%b want 0", bus.locked);
    end
    step(1'b1, 1'b0, 4'h3, 4'hC);
    n_cmp++;
    if ({bus.locked, bus.up_dir, bus.down_dir, bus.error_pulse} !== 4'b1100) begin
      n_bad++;
      $display("FAIL lock_rise lk/ud/dd/ep=%b%b%b%b want 1100",
               bus.locked, bus.up_dir, bus.down_dir, bus.error_pulse);
    end
  endtask

  task automatic test_wrap_and_glitch();
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 4'(4 + k), 4'(11 - k));
    n_cmp++;
    if ({bus.locked, bus.error_count} !== {1'b1, 8'd0}) begin
      n_bad++; $display("FAIL wrap_no_error lk=%b ec=%0d want lk=1 ec=0", bus.locked, bus.error_count);
    end
    step(1'b1, 1'b0, 4'h5, 4'hD);      // Up jumps 1 -> 5
    n_cmp++;
    if (bus.error_pulse !== 1'b0) begin
      n_bad++; $display("FAIL glitch_latency ep=%b want 0", bus.error_pulse);
    end
    step(1'b1, 1'b0, 4'h6, 4'hC);
    n_cmp++;
    if ({bus.error_pulse, bus.error_count} !== {1'b1, 8'd1}) begin
      n_bad++; $display("FAIL glitch_pulse ep=%b ec=%0d want ep=1 ec=1", bus.error_pulse, bus.error_count);
    end
    step(1'b1, 1'b0, 4'h7, 4'hB);
    n_cmp++;
    if ({bus.error_pulse, bus.error_count} !== {1'b0, 8'd1}) begin
      n_bad++; $display("FAIL glitch_single ep=%b ec=%0d want ep=0 ec=1", bus.error_pulse, bus.error_count);
    end
  endtask

  task automatic test_hold();
    step(1'b0, 1'b0, 4'h8, 4'hA);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h8, 4'hA);
    n_cmp++;
    if ({bus.error_pulse, bus.error_count} !== {1'b0, 8'd1}) begin
      n_bad++; $display("FAIL hold_clean ep=%b ec=%0d want ep=0 ec=1", bus.error_pulse, bus.error_count);
    end
    step(1'b0, 1'b0, 4'h9, 4'hA);      // moves while disabled
    step(1'b0, 1'b0, 4'h9, 4'hA);
    n_cmp++;
    if ({bus.error_pulse, bus.error_count} !== {1'b1, 8'd2}) begin
      n_bad++; $display("FAIL hold_move ep=%b ec=%0d want ep=1 ec=2", bus.error_pulse, bus.error_count);
    end
  endtask

  task automatic test_swap();
    step(1'b1, 1'b1, 4'h9, 4'hA);
    step(1'b1, 1'b1, 4'h8, 4'hB);
    n_cmp++;
    if (bus.locked !== 1'b0) begin
      n_bad++; $display("FAIL swap_unlock locked=%b want 0", bus.locked);
    end
    step(1'b1, 1'b1, 4'h7, 4'hC);
    step(1'b1, 1'b1, 4'h6, 4'hD);
    n_cmp++;
    if ({bus.locked, bus.up_dir, bus.down_dir} !== 3'b101) begin
      n_bad++; $display("FAIL swap_relock lk/ud/dd=%b%b%b want 101", bus.locked, bus.up_dir, bus.down_dir);
    end
    step(1'b1, 1'b1, 4'h5, 4'hE);
    step(1'b0, 1'b0, 4'h4, 4'hF);
    step(1'b0, 1'b0, 4'h4, 4'hF);
    n_cmp++;
    if ({bus.locked, bus.error_count} !== {1'b1, 8'd2}) begin
      n_bad++; $display("FAIL swap_single_relock lk=%b ec=%0d want lk=1 ec=2", bus.locked, bus.error_count);
    end
  endtask

  task automatic test_saturate_and_reset();
    obs_t a;
    for (int i = 0; i < 310; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 4'h5 : 4'h4, 4'hF);
    n_cmp++;
    if (bus.error_count !== 8'hFF) begin
      n_bad++; $display("FAIL saturate ec=%0d want 255", bus.error_count);
    end
    #3 rst = 1'b1;
    model_reset();
    #1;
    a = observe();
    n_cmp++;
    if (a !== RST_OBS) begin
      n_bad++; $display("FAIL reset_mid_async got %h want %h", a, RST_OBS);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap_and_glitch();
    test_hold();
    test_swap();
    test_saturate_and_reset();
    test_lock();                       // relock straight after a mid-stream reset
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
